// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and FSM encoding for the fifo_memory reader-side controller.
package fifo_ctrl_pkg;

  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int SKID_DEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry in-order output buffer; head entry drives the stream, push lands at the next edge.
// Push and pop in the same cycle leave occupancy unchanged; the caller guarantees no overflow.
module fifo_out_skid #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_SIZE-1:0] push_data_i,
  input  logic                 pop_i,
  output logic [1:0]           occ_o,
  output logic [DATA_SIZE-1:0] head_data_o,
  output logic                 head_valid_o
);
  import fifo_ctrl_pkg::*;

  logic [DATA_SIZE-1:0] mem_q [SKID_DEPTH];
  logic                 rd_ptr_q;
  logic [1:0]           occ_q;
  logic [1:0]           occ_d;
  logic                 wr_ptr;

  // Tail slot sits one past the head when a single entry is held.
  assign wr_ptr = rd_ptr_q ^ occ_q[0];

  always_comb begin
    occ_d = occ_q;
    if (push_i && !pop_i) begin
      occ_d = occ_q + 2'd1;
    end else if (pop_i && !push_i) begin
      occ_d = occ_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr] <= push_data_i;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

  assign occ_o        = occ_q;
  assign head_data_o  = mem_q[rd_ptr_q];
  assign head_valid_o = (occ_q != 2'd0);

endmodule

// File: rtl/fifo_read_controller.sv
// Reads a programmed burst from fifo_memory and streams it out in order over valid/ready.
// RE at edge E lands in the skid at E+1; reads stop once buffered plus in-flight words fill both slots.
module fifo_read_controller #(
  parameter int ADDR_SIZE = 3,
  parameter int DEPTH     = 8,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   burst_len,
  input  logic [1:0]           fifo_st,
  input  logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 fifo_re,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE:0]   rd_count
);
  import fifo_ctrl_pkg::*;

  localparam int         CNT_W   = ADDR_SIZE + 1;
  localparam logic [2:0] CREDITS = 3'(SKID_DEPTH);

  if (DEPTH != (1 << ADDR_SIZE)) begin : g_depth_chk
    $error("DEPTH must equal 2**ADDR_SIZE");
  end

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] rd_count_q, rd_count_d;
  logic             inflight_q;
  logic             pop;
  logic [1:0]       buf_occ;
  logic [2:0]       slots_used;
  logic             unused_full;

  assign unused_full = fifo_st[ST_FULL_BIT];

  fifo_out_skid #(
    .DATA_SIZE(DATA_SIZE)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .push_i       (inflight_q),
    .push_data_i  (fifo_data_out),
    .pop_i        (pop),
    .occ_o        (buf_occ),
    .head_data_o  (m_data),
    .head_valid_o (m_valid)
  );

  assign pop = m_valid && m_ready;

  // A word popped this cycle frees its slot before a read issued now can land,
  // which is what keeps RE high back-to-back when the consumer is keeping up.
  assign slots_used = 3'(buf_occ) + 3'(inflight_q) - 3'(pop);

  assign fifo_re  = (state_q == RUN) && !fifo_st[ST_EMPTY_BIT] &&
                    (issued_q < len_q) && (slots_used < CREDITS);
  assign busy     = (state_q == RUN) || (state_q == FLUSH);
  assign done     = (state_q == DONE);
  assign rd_count = rd_count_q;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    issued_d   = fifo_re ? issued_q + CNT_W'(1) : issued_q;
    rd_count_d = pop ? rd_count_q + CNT_W'(1) : rd_count_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = burst_len;
          issued_d   = '0;
          rd_count_d = '0;
          state_d    = (burst_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issued_q == len_q) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!inflight_q && (buf_occ == 2'd0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      rd_count_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      rd_count_q <= rd_count_d;
      inflight_q <= fifo_re;
    end
  end

endmodule
